tnn_cls_arbiter: RTL and testbench

- Shares one combinational approximate TNN classifier core between NREQ requesters. The core has a 10-bit input (five 2-bit features, {e,d,c,b,a} packed, a in bits [1:0]) and a 1-bit class output.
- Arbitrates round-robin, registers the winning feature vector onto the core inputs, captures the class after one evaluation cycle and returns it with the requester tag.
- Keeps saturating classification statistics against an optional ground-truth label.
- Sits between the sample streamers and the evolved classifier netlist, which is instantiated outside this block.

---
 rtl/tnn_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/tnn_cls_arbiter.sv | 137 +++++++++++++
 tb/tb_tnn_cls_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_ctrl_pkg.sv
// Shared types and constants for the TNN classifier control blocks.
package tnn_ctrl_pkg;

  // Packed feature vector: five 2-bit features {e,d,c,b,a}, a in the LSBs.
  localparam int unsigned FEAT_W_DEF = 10;
  localparam int unsigned FEAT_BITS  = 2;
  localparam int unsigned NUM_FEAT   = 5;

  // LSB position of each feature inside the packed vector.
  localparam int unsigned FEAT_A_LSB = 0;
  localparam int unsigned FEAT_B_LSB = 2;
  localparam int unsigned FEAT_C_LSB = 4;
  localparam int unsigned FEAT_D_LSB = 6;
  localparam int unsigned FEAT_E_LSB = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StResp = 2'd2
  } tnn_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned TAG_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [TAG_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [TAG_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = TAG_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tnn_cls_arbiter.sv
// Round-robin sharing of one combinational TNN classifier core, with result
// return and saturating classification statistics.
module tnn_cls_arbiter
  import tnn_ctrl_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned TAG_W  = 2,
  parameter int unsigned FEAT_W = FEAT_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*FEAT_W-1:0] req_data,
  input  logic [NREQ-1:0]        req_label,
  output logic [FEAT_W-1:0]      core_in,
  input  logic                   core_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_class,
  output logic                   rsp_match,
  input  logic                   stat_clr,
  output logic [CNT_W-1:0]       cnt_total,
  output logic [CNT_W-1:0]       cnt_pos,
  output logic [CNT_W-1:0]       cnt_err
);

  tnn_state_e        state_q, state_d;
  logic [TAG_W-1:0]  rr_ptr_q;
  logic [FEAT_W-1:0] core_in_q;
  logic [TAG_W-1:0]  tag_q;
  logic              label_q;
  logic              class_q;
  logic              match_q;
  logic [CNT_W-1:0]  total_q, pos_q, err_q;

  logic [NREQ-1:0]   gnt;
  logic [TAG_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              req_hs;
  logic              rsp_hs;

  localparam logic [CNT_W-1:0] CntMax = '1;

  rr_arbiter #(
    .NREQ  (NREQ),
    .TAG_W (TAG_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_hs = (state_q == StIdle) && gnt_any && rst_n;
  assign rsp_hs = (state_q == StResp) && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_hs) state_d = StEval;
      StEval:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; req_ready is forced low while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    if (state_q == StIdle && rst_n) req_ready = gnt;
    if (state_q == StResp)          rsp_valid = 1'b1;
  end

  // Sample capture, result capture and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in_q <= '0;
      tag_q     <= '0;
      label_q   <= 1'b0;
      class_q   <= 1'b0;
      match_q   <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      if (req_hs) begin
        core_in_q <= req_data[gnt_idx*FEAT_W +: FEAT_W];
        tag_q     <= gnt_idx;
        label_q   <= req_label[gnt_idx];
      end
      if (state_q == StEval) begin
        class_q <= core_out;
        match_q <= (core_out == label_q);
      end
      // Served requester drops to lowest priority.
      if (rsp_hs) begin
        rr_ptr_q <= (tag_q == TAG_W'(NREQ - 1)) ? '0 : tag_q + 1'b1;
      end
    end
  end

  // Saturating statistics; clear has priority over a coincident response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      pos_q   <= '0;
      err_q   <= '0;
    end else if (stat_clr) begin
      total_q <= '0;
      pos_q   <= '0;
      err_q   <= '0;
    end else if (rsp_hs) begin
      if (total_q != CntMax)            total_q <= total_q + 1'b1;
      if (class_q && pos_q != CntMax)   pos_q   <= pos_q + 1'b1;
      if (!match_q && err_q != CntMax)  err_q   <= err_q + 1'b1;
    end
  end

  assign core_in   = core_in_q;
  assign rsp_tag   = tag_q;
  assign rsp_class = class_q;
  assign rsp_match = match_q;
  assign cnt_total = total_q;
  assign cnt_pos   = pos_q;
  assign cnt_err   = err_q;

endmodule

// File: tb/tb_tnn_cls_arbiter.sv
// Self-checking bench for tnn_cls_arbiter with a behavioural reference model.
// Counters are narrowed to 8 bits so saturation is reachable in a short run.
module tb_tnn_cls_arbiter;

  localparam int NREQ   = 4;
  localparam int TAG_W  = 2;
  localparam int FEAT_W = 10;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NREQ-1:0]        req_valid, req_ready, req_label;
  logic [NREQ*FEAT_W-1:0] req_data;
  logic [FEAT_W-1:0]      core_in;
  logic                   core_out;
  logic                   rsp_valid, rsp_ready, rsp_class, rsp_match, stat_clr;
  logic [TAG_W-1:0]       rsp_tag;
  logic [CNT_W-1:0]       cnt_total, cnt_pos, cnt_err;

  int core_mode = 2;
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int m_ptr, m_total, m_pos, m_err;

  tnn_cls_arbiter #(
    .NREQ   (NREQ),
    .TAG_W  (TAG_W),
    .FEAT_W (FEAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_label (req_label),
    .core_in   (core_in),
    .core_out  (core_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_tag   (rsp_tag),
    .rsp_class (rsp_class),
    .rsp_match (rsp_match),
    .stat_clr  (stat_clr),
    .cnt_total (cnt_total),
    .cnt_pos   (cnt_pos),
    .cnt_err   (cnt_err)
  );

  always #5 clk = ~clk;

  // Stand-in classifier: constant 0, constant 1, or "feature sum >= 8".
  function automatic logic core_fn(input logic [9:0] x, input int mode);
    int s;
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    s = int'(x[1:0]) + int'(x[3:2]) + int'(x[5:4]) + int'(x[7:6]) + int'(x[9:8]);
    return (s >= 8);
  endfunction

  assign core_out = core_fn(core_in, core_mode);

  function automatic logic [9:0] slice(input logic [39:0] d, input int i);
    return d[i*10 +: 10];
  endfunction

  function automatic int model_grant(input logic [3:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_total = 0; m_pos = 0; m_err = 0;
  endtask

  task automatic model_deliver(input int tag, input bit cls, input bit mt);
    if (m_total < CMAX) m_total++;
    if (cls && m_pos < CMAX) m_pos++;
    if (!mt && m_err < CMAX) m_err++;
    m_ptr = (tag + 1) % NREQ;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid = '0; rsp_ready = 1'b0; stat_clr = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // Drives one request until accepted, then walks it through EVAL and RESP,
  // holding the response for 'hold' cycles. Returns what it observed.
  task automatic serve(input logic [3:0] v, input logic [39:0] d, input logic [3:0] lab,
                       input int hold, output bit ok, output logic [3:0] g,
                       output logic [9:0] ci, output logic ve, output logic vr,
                       output logic [1:0] tg, output logic cl, output logic mt);
    int n;
    ok = 0; g = '0; ci = '0; ve = 1'bx; vr = 1'bx; tg = 'x; cl = 1'bx; mt = 1'bx;
    req_valid = v; req_data = d; req_label = lab; rsp_ready = 1'b0; n = 0;
    #1;
    while (req_ready == '0 && n < 10) begin tick(); n++; end
    g = req_ready;
    if (req_ready == '0) begin req_valid = '0; return; end
    tick();
    req_valid = '0; ve = rsp_valid; ci = core_in;
    tick();
    vr = rsp_valid; tg = rsp_tag; cl = rsp_class; mt = rsp_match;
    repeat (hold) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ok = 1;
  endtask

  // All requesters valid, response always accepted, for n delivered responses.
  task automatic run_stream(input int n, output int got);
    int cyc;
    got = 0; cyc = 0;
    req_valid = '1; rsp_ready = 1'b1;
    while (got < n && cyc < n * 3 + 20) begin
      if (rsp_valid) begin
        got++;
        model_deliver(m_ptr, core_fn(10'h0, core_mode), 1'b0);
      end
      tick();
      cyc++;
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '1; rsp_ready = 1'b0; stat_clr = 1'b0; req_data = '0; req_label = '0;
    rst_n = 1'b0;
    tick();
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready got %h want 0", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_tag, rsp_class, rsp_match} !== 5'b0) begin n_err++;
      $display("FAIL reset_rsp got %b%h%b%b want zeros", rsp_valid, rsp_tag, rsp_class, rsp_match); end
    n_cmp++; if (core_in !== 10'h0) begin n_err++; $display("FAIL reset_core_in got %h want 0", core_in); end
    n_cmp++; if ({cnt_total, cnt_pos, cnt_err} !== '0) begin n_err++;
      $display("FAIL reset_cnt got %h %h %h want 0", cnt_total, cnt_pos, cnt_err); end
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_single();
    bit ok; logic [3:0] g; logic [9:0] ci; logic ve, vr, cl, mt; logic [1:0] tg;
    logic [39:0] d;
    d = {10'h000, 10'h2D5, 10'h000, 10'h000};
    core_mode = 1;
    serve(4'b0100, d, 4'b0100, 0, ok, g, ci, ve, vr, tg, cl, mt);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_accept got none want 0100"); end
    n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b want 0100", g); end
    n_cmp++; if (ve !== 1'b0) begin n_err++; $display("FAIL single_eval_valid got %b want 0", ve); end
    n_cmp++; if (vr !== 1'b1) begin n_err++; $display("FAIL single_latency got %b want 1", vr); end
    n_cmp++; if (ci !== 10'h2D5) begin n_err++; $display("FAIL single_core_in got %h want 2d5", ci); end
    n_cmp++; if ({tg, cl, mt} !== {2'd2, 1'b1, 1'b1}) begin n_err++;
      $display("FAIL single_rsp got tag %0d cls %b mt %b want 2 1 1", tg, cl, mt); end
    model_deliver(2, 1'b1, 1'b1);
    n_cmp++; if ({int'(cnt_total), int'(cnt_pos), int'(cnt_err)} !== {32'd1, 32'd1, 32'd0}) begin n_err++;
      $display("FAIL single_cnt got %0d %0d %0d want 1 1 0", cnt_total, cnt_pos, cnt_err); end
  endtask

  task automatic test_round_robin();
    int tags[$]; int cycs[$]; int cyc; bit multi; logic [39:0] d; bit cls_ok;
    apply_reset();
    core_mode = 2;
    d = {$urandom(), $urandom()};
    req_data = d; req_label = 4'b1010;
    req_valid = '1; rsp_ready = 1'b1;
    cyc = 0; multi = 0; cls_ok = 1;
    while (tags.size() < 5 && cyc < 40) begin
      if ($countones(req_ready) > 1) multi = 1;
      if (rsp_valid) begin
        tags.push_back(int'(rsp_tag)); cycs.push_back(cyc);
        if (rsp_class !== core_fn(slice(d, int'(rsp_tag)), 2)) cls_ok = 0;
      end
      tick(); cyc++;
    end
    req_valid = '0; rsp_ready = 1'b0;
    n_cmp++; if (tags.size() != 5) begin n_err++; $display("FAIL rr_count got %0d want 5", tags.size()); end
    n_cmp++; if (multi) begin n_err++; $display("FAIL rr_onehot got multi-hot want one-hot or zero"); end
    n_cmp++; if (!cls_ok) begin n_err++; $display("FAIL rr_class got wrong class want core model"); end
    for (int i = 0; i < tags.size(); i++) begin
      n_cmp++; if (tags[i] != i % NREQ) begin n_err++; $display("FAIL rr_tag%0d got %0d want %0d", i, tags[i], i % NREQ); end
      if (i > 0) begin
        n_cmp++; if (cycs[i] - cycs[i-1] != 3) begin n_err++;
          $display("FAIL rr_gap%0d got %0d want 3", i, cycs[i] - cycs[i-1]); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      bit c;
      c = core_fn(slice(d, i % NREQ), 2);
      model_deliver(i % NREQ, c, c == req_label[i % NREQ]);
    end
    tick();
    n_cmp++; if ({int'(cnt_total), int'(cnt_pos), int'(cnt_err)} !== {m_total, m_pos, m_err}) begin n_err++;
      $display("FAIL rr_cnt got %0d %0d %0d want %0d %0d %0d", cnt_total, cnt_pos, cnt_err, m_total, m_pos, m_err); end
  endtask

  task automatic test_backpressure();
    logic [39:0] d; logic [1:0] tg0; logic cl0; bit held; int n; int gi;
    core_mode = 2;
    d = {$urandom(), $urandom()};
    gi = model_grant(4'b1000);
    req_valid = 4'b1000; req_data = d; req_label = 4'b0000; rsp_ready = 1'b0;
    #1; n = 0;
    while (req_ready == '0 && n < 10) begin tick(); n++; end
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_grant got %b want 1000", req_ready); end
    tick(); req_valid = '0;
    tick();
    tg0 = rsp_tag; cl0 = rsp_class;
    n_cmp++; if (tg0 !== 2'(gi)) begin n_err++; $display("FAIL bp_tag got %0d want %0d", tg0, gi); end
    n_cmp++; if (cl0 !== core_fn(slice(d, 3), 2)) begin n_err++; $display("FAIL bp_class got %b want %b", cl0, core_fn(slice(d, 3), 2)); end
    req_valid = '1; held = 1;
    repeat (10) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_tag !== tg0 || rsp_class !== cl0 || req_ready !== '0
          || int'(cnt_total) != m_total) held = 0;
    end
    n_cmp++; if (!held) begin n_err++; $display("FAIL bp_hold got change during stall want held"); end
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    model_deliver(3, cl0, cl0 == 1'b0);
    n_cmp++; if (int'(cnt_total) != m_total) begin n_err++; $display("FAIL bp_cnt got %0d want %0d", cnt_total, m_total); end
  endtask

  task automatic test_mismatch();
    bit ok; logic [3:0] g; logic [9:0] ci; logic ve, vr, cl, mt; logic [1:0] tg; int gi;
    core_mode = 0;
    gi = model_grant(4'b0011);
    serve(4'b0011, {$urandom(), $urandom()}, 4'b1111, 0, ok, g, ci, ve, vr, tg, cl, mt);
    n_cmp++; if ({ok, tg} !== {1'b1, 2'(gi)}) begin n_err++; $display("FAIL mis_tag got %0d want %0d", tg, gi); end
    n_cmp++; if ({cl, mt} !== 2'b00) begin n_err++; $display("FAIL mis_rsp got cls %b mt %b want 0 0", cl, mt); end
    model_deliver(gi, 1'b0, 1'b0);
    n_cmp++; if ({int'(cnt_pos), int'(cnt_err)} !== {m_pos, m_err}) begin n_err++;
      $display("FAIL mis_cnt got pos %0d err %0d want %0d %0d", cnt_pos, cnt_err, m_pos, m_err); end
  endtask

  task automatic test_random();
    bit ok; logic [3:0] g; logic [9:0] ci; logic ve, vr, cl, mt; logic [1:0] tg;
    logic [3:0] v, lab; logic [39:0] d; int gi; bit ec;
    core_mode = 2;
    for (int it = 0; it < 30; it++) begin
      v = 4'($urandom_range(1, 15)); lab = 4'($urandom()); d = {$urandom(), $urandom()};
      gi = model_grant(v);
      ec = core_fn(slice(d, gi), 2);
      serve(v, d, lab, int'($urandom_range(0, 3)), ok, g, ci, ve, vr, tg, cl, mt);
      n_cmp++; if (!ok || g !== 4'(1 << gi)) begin n_err++; $display("FAIL rnd%0d_grant got %b want %b", it, g, 4'(1 << gi)); end
      n_cmp++; if (ci !== slice(d, gi)) begin n_err++; $display("FAIL rnd%0d_core_in got %h want %h", it, ci, slice(d, gi)); end
      n_cmp++; if ({ve, vr, tg, cl, mt} !== {1'b0, 1'b1, 2'(gi), ec, ec == lab[gi]}) begin n_err++;
        $display("FAIL rnd%0d_rsp got %b %b %0d %b %b want 0 1 %0d %b %b", it, ve, vr, tg, cl, mt, gi, ec, ec == lab[gi]); end
      model_deliver(gi, ec, ec == lab[gi]);
      n_cmp++; if ({int'(cnt_total), int'(cnt_pos), int'(cnt_err)} !== {m_total, m_pos, m_err}) begin n_err++;
        $display("FAIL rnd%0d_cnt got %0d %0d %0d want %0d %0d %0d", it, cnt_total, cnt_pos, cnt_err, m_total, m_pos, m_err); end
    end
  endtask

  task automatic test_saturation();
    int got;
    apply_reset();
    core_mode = 1; req_label = '0; req_data = '0;
    run_stream(CMAX, got);
    n_cmp++; if (got != CMAX) begin n_err++; $display("FAIL sat_stream got %0d want %0d", got, CMAX); end
    n_cmp++; if ({int'(cnt_total), int'(cnt_pos), int'(cnt_err)} !== {m_total, m_pos, m_err}) begin n_err++;
      $display("FAIL sat_full got %0d %0d %0d want %0d %0d %0d", cnt_total, cnt_pos, cnt_err, m_total, m_pos, m_err); end
    run_stream(1, got);
    n_cmp++; if ({int'(cnt_total), int'(cnt_pos), int'(cnt_err)} !== {CMAX, CMAX, CMAX}) begin n_err++;
      $display("FAIL sat_hold got %0d %0d %0d want %0d", cnt_total, cnt_pos, cnt_err, CMAX); end
  endtask

  task automatic test_clear_coincide();
    int n;
    req_valid = '1; rsp_ready = 1'b0; n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    req_valid = '0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL clr_resp got %b want 1", rsp_valid); end
    rsp_ready = 1'b1; stat_clr = 1'b1;
    tick();
    rsp_ready = 1'b0; stat_clr = 1'b0;
    m_ptr = (m_ptr + 1) % NREQ; m_total = 0; m_pos = 0; m_err = 0;
    n_cmp++; if ({cnt_total, cnt_pos, cnt_err} !== '0) begin n_err++;
      $display("FAIL clr_cnt got %0d %0d %0d want 0 0 0", cnt_total, cnt_pos, cnt_err); end
  endtask

  task automatic test_reset_eval();
    bit ok; logic [3:0] g; logic [9:0] ci; logic ve, vr, cl, mt; logic [1:0] tg; int n;
    core_mode = 1;
    serve(4'b0100, {$urandom(), $urandom()}, 4'b0000, 0, ok, g, ci, ve, vr, tg, cl, mt);
    // Leave the pointer non-zero, then abort a transaction in EVAL.
    req_valid = 4'b1000; n = 0;
    #1;
    while (req_ready == '0 && n < 10) begin tick(); n++; end
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid, req_ready} !== 5'b0) begin n_err++; $display("FAIL rst_eval_vld got %b %b want 0", rsp_valid, req_ready); end
    n_cmp++; if ({cnt_total, cnt_pos, cnt_err} !== '0) begin n_err++;
      $display("FAIL rst_eval_cnt got %0d %0d %0d want 0", cnt_total, cnt_pos, cnt_err); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_eval_norsp got %b want 0", rsp_valid); end
    rst_n = 1'b1;
    tick();
    model_reset();
    // Pointer back at 0: requester 1 beats requester 3.
    serve(4'b1010, {$urandom(), $urandom()}, 4'b0010, 0, ok, g, ci, ve, vr, tg, cl, mt);
    n_cmp++; if ({ok, g, tg} !== {1'b1, 4'b0010, 2'd1}) begin n_err++; $display("FAIL rst_eval_next got %b tag %0d want 0010 tag 1", g, tg); end
    n_cmp++; if ({cl, mt, int'(cnt_total)} !== {1'b1, 1'b1, 32'd1}) begin n_err++;
      $display("FAIL rst_eval_cnt2 got %b %b %0d want 1 1 1", cl, mt, cnt_total); end
  endtask

  initial begin
    req_valid = '0; req_data = '0; req_label = '0; rsp_ready = 1'b0; stat_clr = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mismatch();
    test_random();
    test_saturation();
    test_clear_coincide();
    test_reset_eval();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
